mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
Initiator-side controller that drives the 8-entry memory block's write/read port (en_w, en_r, address, data_in, data_out, full/empty flags). It accepts burst commands over a valid/ready interface and streams write data in and read data out. Bursts access consecutive addresses starting from a given address. It replaces hand-sequenced en_w/en_r/address driving in system logic and benches.

Parameters:
DW, 8, data width; must match the memory data width.
AW, 3, address width; depth = 2**AW.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller can accept a command (IDLE only)
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  AW  burst length minus one (0 → 1 beat, 7 → 8 beats)
wr_valid  in  1  write beat available
wr_ready  out  1  controller accepts write beat
wr_data  in  DW  write beat data
rd_valid  out  1  rd_data valid this cycle (no backpressure)
rd_data  out  DW  read beat data
done  out  1  one-cycle pulse: burst finished or aborted
err  out  1  one-cycle pulse: command rejected or burst aborted
mem_en_w  out  1  to memory en_w
mem_en_r  out  1  to memory en_r
mem_address  out  AW  to memory address
mem_data_in  out  DW  to memory data_in
mem_data_out  in  DW  from memory data_out; valid one cycle after en_r is sampled
mem_full  in  1  from memory full_flag
mem_empty  in  1  from memory empty_flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. mem_en_w, mem_en_r, mem_address, mem_data_in, rd_valid, done, err, and the beat counter all clear to 0. Reset asserted mid-burst aborts the burst immediately. No done pulse is produced on reset.
- All mem_* outputs, done, and err are registered. rd_data = mem_data_out (pass-through). rd_valid is registered.
- FSM states: IDLE, WR, RD, RD_DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is consumed: cur_addr←cmd_addr, remaining←cmd_len.
  - Write command with mem_full=1: err=1 and done=1 next cycle; stay IDLE.
  - Read command with mem_empty=1: err=1 and done=1 next cycle; stay IDLE.
  - Otherwise go to WR or RD.
- WR:
  - wr_ready=1.
  - Beat accepted in cycle N (wr_valid&wr_ready): in cycle N+1, mem_en_w=1, mem_address=cur_addr, mem_data_in=wr_data.
  - wr_valid=0 is a stall: mem_en_w=0 next cycle and the address holds.
  - After the beat with remaining==0 is accepted: wr_ready drops, next cycle done=1, state→IDLE.
- WR abort: if mem_full=1 while in WR, no further beats are accepted, err=1 and done=1 next cycle, state→IDLE. A beat accepted in the same cycle is dropped.
- RD:
  - Issues one read per cycle with no stalls: mem_en_r=1, mem_address=cur_addr.
  - rd_valid is asserted exactly one cycle after each mem_en_r cycle.
  - After issuing the beat with remaining==0 → RD_DRAIN.
- RD_DRAIN: lasts one cycle, during which the last rd_valid is presented. done=1 in the following cycle, state→IDLE.
- Read latency: command accepted in cycle C → first rd_valid in C+2; a burst of L beats ends with done in C+L+2.
- Address arithmetic: cur_addr increments modulo 2**AW after each beat (7→0 wraps). The length counter never wraps.
- Command handling outside IDLE: cmd_ready=0; cmd_valid is ignored.
- Mutual exclusion: mem_en_w and mem_en_r are never both 1.
- done and err are never asserted for more than one consecutive cycle.

Decomposition:
- Shared package mem_pkg: DW/AW defaults and the state encoding (IDLE=0, WR=1, RD=2, RD_DRAIN=3).
- One natural sub-module: mem_addr_seq. It holds the start-address load, the modulo increment, and the remaining-beat down-counter with a last flag. It is shared by the WR and RD paths.

Test Plan:
- Write burst, addr=0, len=7, wr_valid held high, data 0..7 → mem_en_w high 8 consecutive cycles at addresses 0..7 with data 0..7; done pulse once; err=0.
- Read burst, addr=0, len=7, memory preloaded with 0..7 → rd_valid high 8 cycles, rd_data 0..7; first rd_valid 2 cycles after cmd accept; done 1 cycle after the last rd_valid.
- Write burst, addr=6, len=3, with wr_valid low for 2 cycles after the 2nd beat → addresses 6,7,0,1; mem_en_w low during the stall; data order preserved.
- Write command while mem_full=1 → no mem_en_w; err=1 and done=1 for one cycle; cmd_ready high again next cycle. Repeat with a read command while mem_empty=1 → same response, no mem_en_r.
- rst driven low mid read burst (3rd beat) → all outputs 0 asynchronously, state IDLE, no done; after release, a new 1-beat read (len=0) completes normally.
- cmd_valid pulsed during an active write burst → ignored (cmd_ready=0); no extra burst issued afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst controller.
// Data/address width defaults and the controller state encoding.
package mem_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD       = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_addr_seq.sv
// Burst address sequencer: start-address load, modulo increment,
// and a remaining-beat down-counter that saturates at zero.
module mem_addr_seq
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] ld_len,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] addr_nxt,
  output logic          last
);

  logic [AW-1:0] rem;

  assign addr_nxt = addr + AW'(1);
  assign last     = (rem == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= ld_addr;
      rem  <= ld_len;
    end else if (step) begin
      addr <= addr_nxt;
      if (!last) rem <= rem - AW'(1);
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst initiator for the 8-entry memory: accepts burst commands,
// streams write beats in and read beats out over consecutive addresses.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  output logic          mem_en_w,
  output logic          mem_en_r,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  input  logic          mem_full,
  input  logic          mem_empty
);

  state_t        state_q, state_d;
  logic          en_w_d, en_r_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;
  logic          rv_d, done_d, err_d;
  logic          load, step;
  logic [AW-1:0] seq_addr, seq_nxt;
  logic          seq_last;

  mem_addr_seq #(.AW(AW)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .ld_addr  (cmd_addr),
    .ld_len   (cmd_len),
    .addr     (seq_addr),
    .addr_nxt (seq_nxt),
    .last     (seq_last)
  );

  // Holding off a command while done is high keeps done/err single-cycle.
  assign cmd_ready = (state_q == IDLE) && !done;
  assign wr_ready  = (state_q == WR);
  assign rd_data   = mem_data_out;

  always_comb begin
    state_d = state_q;
    en_w_d  = 1'b0;
    en_r_d  = 1'b0;
    addr_d  = mem_address;
    data_d  = mem_data_in;
    rv_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load = 1'b1;
          if (cmd_wr) begin
            if (mem_full) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = WR;
            end
          end else if (mem_empty) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RD;
            en_r_d  = 1'b1;
            addr_d  = cmd_addr;
          end
        end
      end
      WR: begin
        if (mem_full) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wr_valid) begin
          en_w_d = 1'b1;
          addr_d = seq_addr;
          data_d = wr_data;
          step   = 1'b1;
          if (seq_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD: begin
        rv_d = 1'b1;
        if (seq_last) begin
          state_d = RD_DRAIN;
        end else begin
          step   = 1'b1;
          en_r_d = 1'b1;
          addr_d = seq_nxt;
        end
      end
      RD_DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_en_w    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_w    <= en_w_d;
      mem_en_r    <= en_r_d;
      mem_address <= addr_d;
      mem_data_in <= data_d;
      rd_valid    <= rv_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: per-cycle vector tables plus
// a hand-sequenced asynchronous reset in the middle of a read burst.
module tb_mem_burst_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic          mem_en_w, mem_en_r;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_full, mem_empty;
  logic [DW-1:0] mem [8];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .done         (done),
    .err          (err),
    .mem_en_w     (mem_en_w),
    .mem_en_r     (mem_en_r),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_full     (mem_full),
    .mem_empty    (mem_empty)
  );

  // Simple memory: write on en_w, read data one cycle after en_r.
  always @(posedge clk) begin
    if (mem_en_w) mem[mem_address] <= mem_data_in;
    if (mem_en_r) mem_data_out <= mem[mem_address];
  end

  typedef struct {
    logic          cv, cw;
    logic [AW-1:0] ca, cl;
    logic          wv;
    logic [DW-1:0] wd;
    logic          fu, em;
    logic          ew, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          rv;
    logic [DW-1:0] rd;
    logic          dn, ee, cr, wr;
  } vec_t;

  vec_t  tq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  string tag;

  task automatic add(input int cv, cw, ca, cl, wv, wd, fu, em,
                     input int ew, er, ea, ed, rv, rd, dn, ee, cr, wr);
    vec_t v;
    v.cv = 1'(cv); v.cw = 1'(cw); v.ca = 3'(ca); v.cl = 3'(cl);
    v.wv = 1'(wv); v.wd = 8'(wd); v.fu = 1'(fu); v.em = 1'(em);
    v.ew = 1'(ew); v.er = 1'(er); v.ea = 3'(ea); v.ed = 8'(ed);
    v.rv = 1'(rv); v.rd = 8'(rd); v.dn = 1'(dn); v.ee = 1'(ee);
    v.cr = 1'(cr); v.wr = 1'(wr);
    tq.push_back(v);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s/%s row %0d: got %0h want %0h",
               tag, nm, row, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_valid = v.cv; cmd_wr = v.cw;
    cmd_addr  = v.ca; cmd_len = v.cl;
    wr_valid  = v.wv; wr_data = v.wd;
    mem_full  = v.fu; mem_empty = v.em;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr  = '0;   cmd_len = '0;
    wr_valid  = 1'b0; wr_data = '0;
    mem_full  = 1'b0; mem_empty = 1'b0;
  endtask

  task automatic check(input vec_t v, input int i);
    chk("en_w", i, 8'(mem_en_w), 8'(v.ew));
    chk("en_r", i, 8'(mem_en_r), 8'(v.er));
    chk("addr", i, 8'(mem_address), 8'(v.ea));
    if (v.ew) chk("wdata", i, mem_data_in, v.ed);
    chk("rd_valid", i, 8'(rd_valid), 8'(v.rv));
    if (v.rv) chk("rd_data", i, rd_data, v.rd);
    chk("done", i, 8'(done), 8'(v.dn));
    chk("err", i, 8'(err), 8'(v.ee));
    chk("cmd_ready", i, 8'(cmd_ready), 8'(v.cr));
    chk("wr_ready", i, 8'(wr_ready), 8'(v.wr));
  endtask

  task automatic run(input string nm);
    tag = nm;
    foreach (tq[i]) begin
      drive(tq[i]);
      @(posedge clk);
      #1;
      check(tq[i], i);
    end
    tq.delete();
    idle();
  endtask

  task automatic reset_zero(input int i);
    chk("en_w", i, 8'(mem_en_w), 8'h00);
    chk("en_r", i, 8'(mem_en_r), 8'h00);
    chk("addr", i, 8'(mem_address), 8'h00);
    chk("wdata", i, mem_data_in, 8'h00);
    chk("rd_valid", i, 8'(rd_valid), 8'h00);
    chk("done", i, 8'(done), 8'h00);
    chk("err", i, 8'(err), 8'h00);
    chk("cmd_ready", i, 8'(cmd_ready), 8'h01);
    chk("wr_ready", i, 8'(wr_ready), 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    tag = "reset";
    reset_zero(0);
    rst = 1'b1;

    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0);
    run("idle");

    // write 0..7 from addr 0, a stray read command at beat 3
    add(1,1,0,7,0,0,0,0, 0,0,0,0,0,0,0,0,0,1);
    for (int k = 1; k <= 8; k++)
      add((k == 3) ? 1 : 0, 0, 4, 2, 1, 'hA0 + k - 1, 0, 0,
          1, 0, k - 1, 'hA0 + k - 1, 0, 0,
          (k == 8) ? 1 : 0, 0, 0, (k != 8) ? 1 : 0);
    add(0,0,0,0,0,0,0,0, 0,0,7,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0,0,0, 0,0,7,0,0,0,0,0,1,0);
    run("wr8");

    // read back 8 beats from addr 0
    add(1,0,0,7,0,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    for (int k = 1; k <= 7; k++)
      add(0,0,0,0,0,0,0,0, 0,1,k,0,1,'hA0 + k - 1,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,7,0,1,'hA7,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,7,0,0,0,1,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,7,0,0,0,0,0,1,0);
    run("rd8");

    // wrapping write from addr 6 with a 2-cycle stall
    add(1,1,6,3,0,0,0,0,    0,0,7,0,0,0,0,0,0,1);
    add(0,0,0,0,1,'hB0,0,0, 1,0,6,'hB0,0,0,0,0,0,1);
    add(0,0,0,0,1,'hB1,0,0, 1,0,7,'hB1,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,0,    0,0,7,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,0,    0,0,7,0,0,0,0,0,0,1);
    add(0,0,0,0,1,'hB2,0,0, 1,0,0,'hB2,0,0,0,0,0,1);
    add(0,0,0,0,1,'hB3,0,0, 1,0,1,'hB3,0,0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,    0,0,1,0,0,0,0,0,1,0);
    run("wrap");

    // rejected commands: write while full, read while empty
    add(1,1,2,1,0,0,1,0, 0,0,1,0,0,0,1,1,0,0);
    add(0,0,0,0,0,0,1,0, 0,0,1,0,0,0,0,0,1,0);
    add(1,0,2,1,0,0,0,1, 0,0,1,0,0,0,1,1,0,0);
    add(0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,1,0);
    run("reject");

    // full rises mid-write: the concurrent beat is dropped
    add(1,1,3,3,0,0,0,0,    0,0,1,0,0,0,0,0,0,1);
    add(0,0,0,0,1,'hC0,0,0, 1,0,3,'hC0,0,0,0,0,0,1);
    add(0,0,0,0,1,'hC1,1,0, 0,0,3,0,0,0,1,1,0,0);
    add(0,0,0,0,0,0,0,0,    0,0,3,0,0,0,0,0,1,0);
    run("abort");

    // read burst cut by reset while issuing the 3rd beat
    add(1,0,0,7,0,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,1,1,0,1,'hB2,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,1,2,0,1,'hB3,0,0,0,0);
    run("rst_pre");
    #2;
    rst = 1'b0;
    #1;
    tag = "rst_async";
    reset_zero(0);
    @(posedge clk);
    #1;
    reset_zero(1);
    rst = 1'b1;

    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0);
    add(1,0,5,0,0,0,0,0, 0,1,5,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,5,0,1,'hA5,0,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,5,0,0,0,1,0,0,0);
    add(0,0,0,0,0,0,0,0, 0,0,5,0,0,0,0,0,1,0);
    run("rst_post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
